haar_cascade_sequencer: RTL and testbench
=========================================

// Module: haar_cascade_sequencer
// PURPOSE
//  Walks the Haar cascade ROM for one detection window: reads the stage count, then per stage its header,
//  threshold and weak-classifier words; hands each classifier to the feature evaluator over a valid/ready
//  handshake, accumulates the returned signed votes and early-rejects on the first failing stage.
//  Sits between the window scanner (start/done) and haar_cascade_rom + haar feature evaluator.
// PARAMETERS
//  ADDR_WIDTH  14  ROM address width; must match the cascade ROM instance
//  DATA_WIDTH  32  ROM word width
//  ACC_WIDTH   32  signed stage accumulator width; saturating
//  STAGE_W     8   width of stage count / stage index
// PORTS
//  clk            in   1           system clock
//  rst_n          in   1           asynchronous active-low reset
//  start          in   1           pulse: evaluate current window; ignored unless busy==0
//  abort          in   1           pulse: cancel evaluation, return to IDLE, no done pulse
//  busy           out  1           high from the cycle after accepted start until done
//  done           out  1           1-cycle pulse: result valid
//  face_detected  out  1           result, held until next accepted start
//  stage_reached  out  STAGE_W     stages passed (== stage count on detection), held with result
//  rom_addr       out  ADDR_WIDTH  registered ROM address
//  rom_data       in   DATA_WIDTH  ROM read data, valid 1 cycle after ROM samples rom_addr
//  feat_valid     out  1           classifier words valid for evaluator
//  feat_desc      out  DATA_WIDTH  classifier word 0 (feature descriptor)
//  feat_leaf      out  DATA_WIDTH  classifier word 1 (threshold/leaf values)
//  feat_ready     in   1           evaluator accepts when feat_valid && feat_ready
//  vote_valid     in   1           1-cycle pulse: evaluator result
//  vote           in   ACC_WIDTH   signed weak-classifier contribution
// BEHAVIOUR
//  Reset: all outputs 0, rom_addr 0, state IDLE, accumulator 0.
//  ROM layout: addr 0 = stage count (bits STAGE_W-1:0); stage block = header word (bits 15:0 = classifier
//   count K), signed threshold word, then K x {desc, leaf}; next stage block follows contiguously from addr 1.
//  ROM read: rom_addr updated at edge E, ROM samples at E+1, sequencer captures rom_data at E+2 (2 cycles/word).
//  States: IDLE -> RD_NSTG -> RD_HDR -> RD_THR -> (K==0 ? CHECK : RD_DESC) -> RD_LEAF -> ISSUE -> WAIT_VOTE
//   -> (more classifiers ? RD_DESC : CHECK); CHECK -> pass&more stages ? RD_HDR : DONE; DONE -> IDLE.
//  Stage count 0: RD_NSTG -> DONE, face_detected=1, stage_reached=0.
//  ISSUE: feat_valid=1, feat_desc/feat_leaf stable until handshake; drop feat_valid the cycle after it.
//  WAIT_VOTE: acc <= sat(acc + vote) on vote_valid; vote_valid outside WAIT_VOTE ignored.
//  Saturation: clamp to +2^(ACC_WIDTH-1)-1 / -2^(ACC_WIDTH-1) on signed overflow.
//  CHECK: pass iff acc >= threshold (signed); acc cleared when entering RD_HDR of next stage.
//  Fail: face_detected=0, stage_reached=index of failing stage (count of passed stages).
//  Pass all: face_detected=1, stage_reached=stage count.
//  DONE: done=1 one cycle, busy falls same cycle; face_detected/stage_reached updated same edge as done.
//  start while busy: ignored. start and abort same cycle in IDLE: abort wins (stay IDLE).
//  abort any busy state: next cycle IDLE, busy=0, feat_valid=0, no done; results keep prior values.
//  Address pointer wrap beyond 2^ADDR_WIDTH-1 wraps to 0 (ROM image is responsible for fitting).
// TESTING
//  1 stage, K=2, votes +5,+7, thr 10 -> done pulse, face_detected=1, stage_reached=1, 2 feat handshakes.
//  3 stages, stage 1 votes sum 3 vs thr 4 -> face_detected=0, stage_reached=1, stage 2 header never addressed.
//  Stage count 0 -> done within 4 cycles of start, face_detected=1, stage_reached=0, feat_valid never high.
//  feat_ready held low 10 cycles -> feat_valid/feat_desc/feat_leaf stable, rom_addr static; then completes.
//  votes 0x7FFFFFF0 + 0x100 -> acc saturates 0x7FFFFFFF, passes thr 0x7FFFFFFF; negative overflow -> 0x80000000.
//  abort during WAIT_VOTE -> busy=0 next cycle, no done; restart gives same result as uninterrupted run.

Source files
------------

// File: rtl/haar_cascade_sequencer.sv
// Haar cascade sequencer: walks the cascade ROM for one window, issues weak classifiers
// to the feature evaluator, accumulates saturating signed votes and early-rejects failing stages.
module haar_cascade_sequencer #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 32,
  parameter int STAGE_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  face_detected,
  output logic [STAGE_W-1:0]    stage_reached,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  feat_valid,
  output logic [DATA_WIDTH-1:0] feat_desc,
  output logic [DATA_WIDTH-1:0] feat_leaf,
  input  logic                  feat_ready,
  input  logic                  vote_valid,
  input  logic [ACC_WIDTH-1:0]  vote
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    RD_NSTG   = 4'd1,
    RD_HDR    = 4'd2,
    RD_THR    = 4'd3,
    RD_DESC   = 4'd4,
    RD_LEAF   = 4'd5,
    ISSUE     = 4'd6,
    WAIT_VOTE = 4'd7,
    CHECK     = 4'd8,
    DONE      = 4'd9
  } state_t;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Signed add clamped to the accumulator range; overflow shows as disagreeing top two sum bits.
  function automatic logic signed [ACC_WIDTH-1:0] sat_add(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b
  );
    logic signed [ACC_WIDTH:0] sum;
    sum = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
      return sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end else begin
      return sum[ACC_WIDTH-1:0];
    end
  endfunction

  state_t                        state_r, next_state_s;
  logic                          phase_r;
  logic [ADDR_WIDTH-1:0]         ptr_r, rom_addr_r;
  logic [STAGE_W-1:0]            nstg_r, stage_idx_r;
  logic [15:0]                   k_r, cls_idx_r;
  logic signed [ACC_WIDTH-1:0]   thr_r, acc_r;
  logic [DATA_WIDTH-1:0]         feat_desc_r, feat_leaf_r;
  logic                          busy_r, done_r, feat_valid_r, face_r;
  logic [STAGE_W-1:0]            reached_r;
  logic                          busy_s, done_s, feat_valid_s, face_s;
  logic [STAGE_W-1:0]            reached_s;
  logic                          in_run_s, is_rd_s, cap_s, pass_s, more_cls_s, more_stg_s;
  logic                          start_run_s, enter_rd_s;

  assign in_run_s    = (state_r != IDLE) && (state_r != DONE);
  assign is_rd_s     = (state_r == RD_NSTG) || (state_r == RD_HDR) || (state_r == RD_THR) ||
                       (state_r == RD_DESC) || (state_r == RD_LEAF);
  // Second cycle of a read state: rom_data holds the word addressed on entry.
  assign cap_s       = is_rd_s && phase_r;
  assign pass_s      = (acc_r >= thr_r);
  assign more_cls_s  = (({1'b0, cls_idx_r} + 17'd1) < {1'b0, k_r});
  assign more_stg_s  = (({1'b0, stage_idx_r} + (STAGE_W+1)'(1)) < {1'b0, nstg_r});
  assign start_run_s = (next_state_s == RD_NSTG) && (state_r != RD_NSTG);
  assign enter_rd_s  = (next_state_s != state_r) &&
                       ((next_state_s == RD_HDR) || (next_state_s == RD_THR) ||
                        (next_state_s == RD_DESC) || (next_state_s == RD_LEAF));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; abort overrides everything while a window is in flight.
  always_comb begin
    next_state_s = state_r;
    if (abort && in_run_s) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE, DONE: next_state_s = (start && !abort) ? RD_NSTG : IDLE;
        RD_NSTG: begin
          if (phase_r) begin
            next_state_s = (rom_data[STAGE_W-1:0] == {STAGE_W{1'b0}}) ? DONE : RD_HDR;
          end else begin
            next_state_s = RD_NSTG;
          end
        end
        RD_HDR:  next_state_s = phase_r ? RD_THR : RD_HDR;
        RD_THR: begin
          if (phase_r) begin
            next_state_s = (k_r == 16'd0) ? CHECK : RD_DESC;
          end else begin
            next_state_s = RD_THR;
          end
        end
        RD_DESC: next_state_s = phase_r ? RD_LEAF : RD_DESC;
        RD_LEAF: next_state_s = phase_r ? ISSUE : RD_LEAF;
        ISSUE:   next_state_s = (feat_valid_r && feat_ready) ? WAIT_VOTE : ISSUE;
        WAIT_VOTE: begin
          if (vote_valid) begin
            next_state_s = more_cls_s ? RD_DESC : CHECK;
          end else begin
            next_state_s = WAIT_VOTE;
          end
        end
        CHECK:   next_state_s = (pass_s && more_stg_s) ? RD_HDR : DONE;
        default: next_state_s = IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    busy_s       = (next_state_s != IDLE) && (next_state_s != DONE);
    done_s       = (next_state_s == DONE);
    feat_valid_s = (next_state_s == ISSUE);
    face_s       = face_r;
    reached_s    = reached_r;
    if (next_state_s == DONE) begin
      if (state_r == RD_NSTG) begin
        face_s    = 1'b1;
        reached_s = {STAGE_W{1'b0}};
      end else if (pass_s) begin
        face_s    = 1'b1;
        reached_s = nstg_r;
      end else begin
        face_s    = 1'b0;
        reached_s = stage_idx_r;
      end
    end else begin
      face_s    = face_r;
      reached_s = reached_r;
    end
  end

  // Datapath: ROM pointer, captured words, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r      <= 1'b0;
      ptr_r        <= {ADDR_WIDTH{1'b0}};
      rom_addr_r   <= {ADDR_WIDTH{1'b0}};
      nstg_r       <= {STAGE_W{1'b0}};
      stage_idx_r  <= {STAGE_W{1'b0}};
      k_r          <= 16'd0;
      cls_idx_r    <= 16'd0;
      thr_r        <= {ACC_WIDTH{1'b0}};
      acc_r        <= {ACC_WIDTH{1'b0}};
      feat_desc_r  <= {DATA_WIDTH{1'b0}};
      feat_leaf_r  <= {DATA_WIDTH{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      feat_valid_r <= 1'b0;
      face_r       <= 1'b0;
      reached_r    <= {STAGE_W{1'b0}};
    end else begin
      // The address only moves when a read state is entered, so it never runs ahead of the walk.
      if (start_run_s) begin
        rom_addr_r <= {ADDR_WIDTH{1'b0}};
        ptr_r      <= ADDR_WIDTH'(1);
      end else if (enter_rd_s) begin
        rom_addr_r <= ptr_r;
        ptr_r      <= ptr_r + ADDR_WIDTH'(1);
      end

      if (next_state_s != state_r) begin
        phase_r <= 1'b0;
      end else if (is_rd_s) begin
        phase_r <= ~phase_r;
      end

      if (cap_s) begin
        case (state_r)
          RD_NSTG: nstg_r <= rom_data[STAGE_W-1:0];
          RD_HDR: begin
            k_r       <= rom_data[15:0];
            cls_idx_r <= 16'd0;
          end
          RD_THR:  thr_r       <= ACC_WIDTH'($signed(rom_data));
          RD_DESC: feat_desc_r <= rom_data;
          RD_LEAF: feat_leaf_r <= rom_data;
          default: ;
        endcase
      end

      if (start_run_s) begin
        stage_idx_r <= {STAGE_W{1'b0}};
        acc_r       <= {ACC_WIDTH{1'b0}};
      end else if ((next_state_s == RD_HDR) && (state_r == CHECK)) begin
        stage_idx_r <= stage_idx_r + STAGE_W'(1);
        acc_r       <= {ACC_WIDTH{1'b0}};
      end else if ((state_r == WAIT_VOTE) && vote_valid && !abort) begin
        acc_r     <= sat_add(acc_r, $signed(vote));
        cls_idx_r <= cls_idx_r + 16'd1;
      end

      busy_r       <= busy_s;
      done_r       <= done_s;
      feat_valid_r <= feat_valid_s;
      face_r       <= face_s;
      reached_r    <= reached_s;
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign feat_valid    = feat_valid_r;
  assign feat_desc     = feat_desc_r;
  assign feat_leaf     = feat_leaf_r;
  assign face_detected = face_r;
  assign stage_reached = reached_r;
  assign rom_addr      = rom_addr_r;

endmodule

// File: tb/tb_haar_cascade_sequencer.sv
// Bench for haar_cascade_sequencer: registered ROM model, randomized evaluator and a
// cascade reference model that scores each window with plain integer arithmetic.
module tb_haar_cascade_sequencer;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int ACCW = 32;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, busy, done, face_detected;
  logic [SW-1:0] stage_reached;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data, feat_desc, feat_leaf;
  logic          feat_valid, feat_ready, vote_valid;
  logic [ACCW-1:0] vote;

  haar_cascade_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACC_WIDTH(ACCW), .STAGE_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .face_detected(face_detected), .stage_reached(stage_reached), .rom_addr(rom_addr),
    .rom_data(rom_data), .feat_valid(feat_valid), .feat_desc(feat_desc), .feat_leaf(feat_leaf),
    .feat_ready(feat_ready), .vote_valid(vote_valid), .vote(vote)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rom_mem [0:(1<<AW)-1];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  int checks = 0;
  int errors = 0;
  int n_stg;
  int k_of [8];
  int thr_of [8];
  int leaf_of [8][4];
  logic [31:0] desc_of [8][4];
  int hdr_addr [8];
  logic [63:0] exp_q [$];
  int hs_cnt, pend, min_dly, hold_left, stable_bad, fv_cnt;
  logic [31:0] pend_vote, snap_d, snap_l;
  logic [AW-1:0] snap_a, watch_addr;
  bit hold_req, watch_en, watch_hit;
  bit last_face;
  int last_reached;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference scoring of the current cascade; also lists the classifier words expected, in order.
  task automatic model(output bit face, output int reached);
    longint acc;
    exp_q.delete();
    face = 1'b1;
    reached = n_stg;
    for (int s = 0; s < n_stg; s++) begin
      acc = 0;
      for (int c = 0; c < k_of[s]; c++) begin
        exp_q.push_back({desc_of[s][c], 32'(leaf_of[s][c])});
        acc = acc + longint'(leaf_of[s][c]);
        if (acc > 64'sd2147483647) acc = 64'sd2147483647;
        if (acc < -64'sd2147483648) acc = -64'sd2147483648;
      end
      if (acc < longint'(thr_of[s])) begin
        face = 1'b0;
        reached = s;
        return;
      end
    end
  endtask

  task automatic set_stage(input int s, input int k, input int thr,
                           input int l0, input int l1, input int l2, input int l3);
    k_of[s] = k;
    thr_of[s] = thr;
    leaf_of[s][0] = l0; leaf_of[s][1] = l1; leaf_of[s][2] = l2; leaf_of[s][3] = l3;
    for (int c = 0; c < 4; c++) desc_of[s][c] = $urandom();
  endtask

  task automatic build_rom();
    int p;
    for (int a = 0; a < 512; a++) rom_mem[a] = 32'($urandom());
    rom_mem[0] = (32'($urandom()) & 32'hFFFF_FF00) | 32'(n_stg);
    p = 1;
    for (int s = 0; s < n_stg; s++) begin
      hdr_addr[s] = p;
      rom_mem[p] = (32'($urandom()) & 32'hFFFF_0000) | 32'(k_of[s]); p++;
      rom_mem[p] = 32'(thr_of[s]); p++;
      for (int c = 0; c < k_of[s]; c++) begin
        rom_mem[p] = desc_of[s][c]; p++;
        rom_mem[p] = 32'(leaf_of[s][c]); p++;
      end
    end
  endtask

  task automatic run_window(input string tag, input bit mid_start, output int cyc);
    bit ef;
    int er, exp_hs;
    model(ef, er);
    exp_hs = exp_q.size();
    hs_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    cyc = 1;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (mid_start && cyc == 5) start = 1'b1;
    end
    start = 1'b0;
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_face"}, 64'(face_detected), 64'(ef));
    check({tag, "_stage"}, 64'(stage_reached), 64'(er));
    check({tag, "_handshakes"}, 64'(hs_cnt), 64'(exp_hs));
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
    last_face = ef;
    last_reached = er;
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  // Feature evaluator: random ready, optional 10-cycle stall, vote = leaf after a short delay.
  initial begin
    feat_ready = 1'b0; vote_valid = 1'b0; vote = '0; pend = 0; hold_left = 0;
    forever begin
      @(negedge clk);
      vote_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin vote_valid = 1'b1; vote = pend_vote; end
      end
      if (hold_left > 0) begin
        feat_ready = 1'b0;
        if (feat_valid !== 1'b1 || feat_desc !== snap_d || feat_leaf !== snap_l || rom_addr !== snap_a)
          stable_bad++;
        hold_left--;
      end else if (hold_req && feat_valid) begin
        hold_req = 1'b0; hold_left = 9; feat_ready = 1'b0;
        snap_d = feat_desc; snap_l = feat_leaf; snap_a = rom_addr;
      end else begin
        feat_ready = ($urandom_range(0, 1) == 1);
      end
      if (feat_valid && feat_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) check("extra_issue", 64'd1, 64'd0);
        else check("feat_words", {feat_desc, feat_leaf}, exp_q.pop_front());
        pend = $urandom_range(min_dly, min_dly + 2);
        pend_vote = feat_leaf;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (feat_valid) fv_cnt++;
      if (watch_en && rom_addr == watch_addr) watch_hit = 1'b1;
    end
  end

  initial begin
    int cyc, w;
    bit saw_done;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; hold_req = 1'b0; min_dly = 1;
    watch_en = 1'b0; watch_hit = 1'b0; stable_bad = 0; fv_cnt = 0;
    n_stg = 0;
    build_rom();
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_fv", 64'(feat_valid), 64'd0);
    check("rst_face", 64'(face_detected), 64'd0);
    check("rst_stage", 64'(stage_reached), 64'd0);
    check("rst_addr", 64'(rom_addr), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // start and abort together while idle: abort wins
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", 64'(busy), 64'd0);

    n_stg = 1; set_stage(0, 2, 10, 5, 7, 0, 0); build_rom();
    run_window("one_stage", 1'b0, cyc);

    n_stg = 3;
    set_stage(0, 1, 2, 4, 0, 0, 0);
    set_stage(1, 2, 4, 1, 2, 0, 0);
    set_stage(2, 1, 0, 9, 0, 0, 0);
    build_rom();
    watch_addr = AW'(hdr_addr[2]); watch_hit = 1'b0; watch_en = 1'b1;
    run_window("early_reject", 1'b0, cyc);
    watch_en = 1'b0;
    check("hdr2_untouched", 64'(watch_hit), 64'd0);

    n_stg = 0; build_rom(); fv_cnt = 0;
    run_window("zero_stages", 1'b0, cyc);
    check("zero_latency", 64'(cyc <= 4), 64'd1);
    check("zero_no_fv", 64'(fv_cnt), 64'd0);

    n_stg = 1; set_stage(0, 2, 10, 5, 7, 0, 0); build_rom();
    stable_bad = 0; hold_req = 1'b1;
    run_window("stall", 1'b0, cyc);
    check("stall_taken", 64'(hold_req), 64'd0);
    check("stall_stable", 64'(stable_bad), 64'd0);

    n_stg = 3;
    set_stage(0, 2, int'(32'h7FFF_FFFF), int'(32'h7FFF_FFF0), int'(32'h0000_0100), 0, 0);
    set_stage(1, 1, int'(32'h8000_0000), -5, 0, 0, 0);
    set_stage(2, 2, int'(32'h8000_0001), int'(32'h8000_0010), int'(32'hFFFF_FF00), 0, 0);
    build_rom();
    run_window("saturate", 1'b0, cyc);

    // abort mid-vote, then rerun the same window
    n_stg = 2; set_stage(0, 2, 3, 2, 2, 0, 0); set_stage(1, 1, 1, 1, 0, 0, 0); build_rom();
    run_window("pre_abort", 1'b0, cyc);
    model(saw_done, w);
    min_dly = 3; hs_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (hs_cnt == 0 && w < 200) begin @(negedge clk); w++; end
    check("abort_reach_issue", 64'(hs_cnt > 0), 64'd1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_fv", 64'(feat_valid), 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    check("abort_no_done", 64'(saw_done), 64'd0);
    check("abort_keep_face", 64'(face_detected), 64'(last_face));
    check("abort_keep_stage", 64'(stage_reached), 64'(last_reached));
    min_dly = 1;
    run_window("after_abort", 1'b0, cyc);

    for (int it = 0; it < 30; it++) begin
      n_stg = $urandom_range(0, 4);
      for (int s = 0; s < n_stg; s++) begin
        set_stage(s, $urandom_range(0, 3), int'($urandom_range(0, 24)) - 8,
                  int'($urandom_range(0, 30)) - 12, int'($urandom_range(0, 30)) - 12,
                  int'($urandom_range(0, 30)) - 12, int'($urandom_range(0, 30)) - 12);
      end
      build_rom();
      run_window($sformatf("rand%0d", it), ($urandom_range(0, 2) == 0), cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
